vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 VGA controller: generates hs, vs, blank and pixel coordinates for any timing set.
- Replaces the derived divided clock with a single-domain pixel clock-enable strobe (pixel_ce), so downstream sprite and background logic stays on Clk.
- Adds selectable sync polarity, run/pause control, and line-start, frame-start and vblank status for frame-synchronous game logic.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types and constants for the VGA timing generator.
//   vga_timing_t   : one axis of a video timing (active, front porch, sync, back porch)
//   VGA_640x480_H/V : standard 640x480@60 axis timings
//   total()        : full period of an axis (active + fp + sync + bp)
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int unsigned total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
//   Clk, Reset : clock, asynchronous active-high reset
//   advance    : step the counter by one position this cycle
//   count      : current position, 0 .. total-1
//   wrap       : count is at its last position (the next advance returns to 0)
//   sync       : sync output at its asserted level POL inside the sync window
//   active     : position lies in the visible region
// sync and active are registered from the next count, so they line up with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam vga_timing_t TIMING = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int unsigned TOTAL  = total(TIMING);

  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ACTIVE_END = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

  logic [WIDTH-1:0] count_next;

  assign wrap = (count == LAST);

  // NOTE: default assigned first so every path writes count_next; no latch.
  always_comb begin
    count_next = count;
    if (advance) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count  <= '0;
      sync   <= ~POL;
      active <= 1'b1;
    end else begin
      count  <= count_next;
      sync   <= ((count_next >= SYNC_START) && (count_next < SYNC_END)) ? POL : ~POL;
      active <= (count_next < ACTIVE_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator on a single clock.
//   Clk, Reset   : system clock, asynchronous active-high reset
//   enable       : run control; low freezes all state and suppresses strobes/pulses
//   pixel_ce     : one-Clk strobe per pixel, every CLK_DIV Clk cycles
//   hs, vs       : syncs, asserted levels HS_POL / VS_POL
//   blank        : 1 while the current pixel is visible
//   sync         : composite sync, constant 0
//   DrawX, DrawY : current pixel / line
//   line_start   : one-Clk pulse when DrawX returns to 0
//   frame_start  : one-Clk pulse when (DrawX, DrawY) returns to (0, 0)
//   in_vblank    : DrawY is outside the visible lines
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW       = 11,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = VGA_640x480_H.active,
  parameter int unsigned H_FP     = VGA_640x480_H.fp,
  parameter int unsigned H_SYNC   = VGA_640x480_H.sync,
  parameter int unsigned H_BP     = VGA_640x480_H.bp,
  parameter int unsigned V_ACTIVE = VGA_640x480_V.active,
  parameter int unsigned V_FP     = VGA_640x480_V.fp,
  parameter int unsigned V_SYNC   = VGA_640x480_V.sync,
  parameter int unsigned V_BP     = VGA_640x480_V.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          enable,
  output logic          pixel_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          in_vblank
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          pce_q;
  logic          line_q;
  logic          frame_q;
  logic          advance;
  logic          h_wrap, v_wrap;
  logic          h_active, v_active;

  // The strobe register holds across a pause, so a pending pixel advance is
  // neither lost nor repeated; only its visibility is gated by enable.
  assign advance = pce_q & enable;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div     <= '0;
      pce_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (enable) begin
        div   <= (div == DIV_LAST) ? '0 : div + 1'b1;
        pce_q <= (div == DIV_LAST);
      end
      // Pulses mark the position just entered; a paused edge clears them.
      line_q  <= advance & h_wrap;
      frame_q <= advance & h_wrap & v_wrap;
    end
  end

  vga_axis_counter #(
    .WIDTH (CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .Clk    (Clk),
    .Reset  (Reset),
    .advance(advance),
    .count  (DrawX),
    .wrap   (h_wrap),
    .sync   (hs),
    .active (h_active)
  );

  // The vertical axis steps on the same edge DrawX wraps, so vs changes
  // together with DrawX returning to 0.
  vga_axis_counter #(
    .WIDTH (CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .Clk    (Clk),
    .Reset  (Reset),
    .advance(advance & h_wrap),
    .count  (DrawY),
    .wrap   (v_wrap),
    .sync   (vs),
    .active (v_active)
  );

  assign pixel_ce    = advance;
  assign line_start  = line_q & enable;
  assign frame_start = frame_q & enable;
  assign blank       = h_active & v_active;
  assign in_vblank   = ~v_active;
  assign sync        = 1'b0;

endmodule
